count_display_driver: RTL and testbench
=======================================

Name: count_display_driver

Overview:
- Consumer end of the 7-bit up/down count bus. Converts the binary count (0..99 legal) to two BCD digits with a sequential double-dabble engine.
- Drives a 2-digit time-multiplexed common-anode seven-segment display.
- Sits between the counter and board pins, all in the Clk domain. The count bus is held stable for many Clk cycles between updates.

Parameters:
- SCAN_DIV, 50000, Clk cycles per digit dwell; must be >= 2.
- SCAN_W, 16, width of the scan divider counter; must satisfy 2^SCAN_W >= SCAN_DIV.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- reset  in  1  reset, synchronous, active-high; clock Clk.
- value  in  7  binary count from the counter.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- an  out  2  digit anodes, active-low; an[0] = ones, an[1] = tens.
- busy  out  1  high while a conversion is in progress.
- ovf  out  1  high when the last converted value was > 99.

Behaviour:
- Reset values:
  - seg = 7'b1111111, an = 2'b11, busy = 0, ovf = 0.
  - tens = 0, ones = 0, last_value = 0.
  - FSM = IDLE; scan counter = 0; digit select = 0 (ones).
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if value != last_value, capture value into the shift register and into last_value, clear the iteration count, set busy = 1, go to SHIFT. Otherwise stay in IDLE.
- SHIFT: exactly 7 cycles. Each cycle:
  - add 3 to any BCD nibble >= 5;
  - shift {bcd[7:0], bin[6:0]} left by 1.
  - After the 7th cycle, go to DONE.
- DONE: one cycle.
  - If the captured value <= 99: tens/ones <= BCD nibbles, ovf <= 0.
  - Else: tens/ones unchanged, ovf <= 1.
  - busy <= 0; go to IDLE.
- Latency: value changes at cycle N (sampled in IDLE) -> tens/ones/ovf valid at cycle N+9; busy high for cycles N+1..N+8.
- While busy, value changes are ignored. After return to IDLE the new value differs from last_value, so it converts next. The final displayed value always equals the final stable input.
- Scan: counter counts 0..SCAN_DIV-1 and wraps. On wrap, digit select toggles. Each digit is displayed for exactly SCAN_DIV cycles.
- Outputs are registered, updated one cycle after the select or digit change:
  - an = 2'b10 (ones) or 2'b01 (tens);
  - seg = decode(selected digit).
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- When ovf = 1, both digits show dash 0111111 regardless of tens/ones.
- Reset mid-conversion aborts to IDLE with the reset values. The next cycle after reset deasserts compares value against last_value = 0.
- Value = 0 right after reset: no conversion runs; display shows "00" (tens shown, see optional feature).
- Value 99 -> 0 wrap, or 0 -> 99 wrap: treated as an ordinary change.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: when tens == 0 and ovf == 0, the tens digit shows blank (seg = 1111111) in its time slot. an still cycles normally.
- Not defined: the tens digit always shows its decoded value, so 7 displays as "07".

Test Plan:
- Reset held 3 cycles with value = 45 -> seg = 1111111, an = 11, busy = 0 during reset. After release, conversion starts next cycle; at +9 the tens slot shows 0011001 and the ones slot shows 0010010.
- value 0 -> 99, SCAN_DIV = 4 -> busy high exactly 8 cycles; then both slots show 0010000; an alternates 10/01 every 4 cycles.
- value = 100 -> ovf = 1 at +9; both slots 0111111. Then value = 12 -> ovf = 0; slots show 1111001 / 0100100.
- Change value 20 -> 30 three cycles after a 10 -> 20 change (mid-SHIFT) -> the first conversion completes showing 20; the second starts immediately after DONE; final display 30.
- Assert reset during SHIFT with value = 88 -> FSM back to IDLE, busy = 0, display regs 0. After release, 88 converts and is displayed within 10 cycles.
- value = 7 with LEADING_ZERO_BLANK_EN defined -> tens slot 1111111, ones 1111000. Not defined -> tens slot 1000000.

Source files
------------

// File: rtl/count_display_driver.sv
// count_display_driver
// Converts the 7-bit count bus (0..99 legal) to two BCD digits with a
// sequential double-dabble engine, then drives a 2-digit time-multiplexed
// common-anode seven-segment display (segments and anodes active-low).
// Optional build macro LEADING_ZERO_BLANK_EN: blanks the tens digit when it
// is zero and no overflow is flagged.
//
// state | meaning
// IDLE  | waiting for value to differ from last_value
// SHIFT | 7 add-3/shift iterations of the double-dabble engine
// DONE  | latch BCD digits or flag overflow, drop busy
module count_display_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int SCAN_W   = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [6:0] value,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0]        SEG_DASH  = 7'b0111111;
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t            state, state_nxt;
    logic [14:0]       shreg;      // {tens nibble, ones nibble, binary}
    logic [14:0]       shreg_adj;
    logic [2:0]        iter;
    logic [6:0]        last_value;
    logic [3:0]        tens, ones;
    logic [SCAN_W-1:0] scan_cnt;
    logic              dsel;       // 0 = ones slot, 1 = tens slot
    logic [3:0]        digit;
    logic [6:0]        seg_nxt;

    // State register
    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (value != last_value) state_nxt = SHIFT;
            SHIFT:   if (iter == 3'd6)        state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on any BCD nibble >= 5 before each shift
    always_comb begin
        shreg_adj = shreg;
        if (shreg[14:11] >= 4'd5) shreg_adj[14:11] = shreg[14:11] + 4'd3;
        if (shreg[10:7]  >= 4'd5) shreg_adj[10:7]  = shreg[10:7]  + 4'd3;
    end

    // Conversion datapath: capture, shift, and result latch
    always_ff @(posedge Clk) begin
        if (reset) begin
            shreg      <= '0;
            iter       <= '0;
            last_value <= '0;
            tens       <= '0;
            ones       <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != last_value) begin
                        shreg      <= {8'd0, value};
                        last_value <= value;
                        iter       <= '0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_adj << 1;
                    iter  <= iter + 3'd1;
                end
                DONE: begin
                    // last_value cannot change while busy, so it still holds
                    // the captured value here
                    if (last_value <= 7'd99) begin
                        tens <= shreg[14:11];
                        ones <= shreg[10:7];
                        ovf  <= 1'b0;
                    end else begin
                        ovf  <= 1'b1;
                    end
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Digit scan: dwell SCAN_DIV cycles per digit, then swap
    always_ff @(posedge Clk) begin
        if (reset) begin
            scan_cnt <= '0;
            dsel     <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dsel     <= ~dsel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Segment pattern for the currently selected digit
    always_comb begin
        digit = dsel ? tens : ones;
        case (digit)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = SEG_BLANK;
        endcase
        if (ovf) begin
            seg_nxt = SEG_DASH;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (dsel && (tens == 4'd0)) begin
            seg_nxt = SEG_BLANK;
        end
`else
`endif
    end

    // Registered pin drivers
    always_ff @(posedge Clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= 2'b11;
        end else begin
            seg <= seg_nxt;
            an  <= dsel ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// Testbench for count_display_driver: table-driven vectors, hand-written
// multi-cycle sequences, and randomized bursts checked against a
// value-level display model.
module tb_count_display_driver;

    localparam int SCAN_DIV = 4;
    localparam int SCAN_W   = 3;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DEC [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                        7'b0110000, 7'b0011001, 7'b0010010,
                                        7'b0000010, 7'b1111000, 7'b0000000,
                                        7'b0010000};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS0 = BLANK;
`else
    localparam logic [6:0] TENS0 = 7'b1000000;
`endif

    logic       Clk = 1'b0;
    logic       reset;
    logic [6:0] value;
    logic [6:0] seg;
    logic [1:0] an;
    logic       busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    count_display_driver #(.SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
        .Clk   (Clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .busy  (busy),
        .ovf   (ovf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         v;
        bit         exp_ovf;
        logic [6:0] exp_tens;
        logic [6:0] exp_ones;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: what a slot must show for a stable input value
    function automatic logic [6:0] exp_seg(input int v, input bit tens_slot);
        int d;
        if (v > 99) return DASH;
        d = tens_slot ? v / 10 : v % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (tens_slot && d == 0) return BLANK;
`endif
        return DEC[d];
    endfunction

    // Watch the scanned display for nsamp cycles, checking every slot and
    // the dwell length of every complete run of one anode pattern
    task automatic check_disp(input string nm, input logic [6:0] et,
                              input logic [6:0] eo, input int nsamp);
        logic [1:0] prev;
        int run;
        bit first_run;
        prev = 2'b00;
        run = 0;
        first_run = 1'b1;
        for (int i = 0; i < nsamp; i++) begin
            step();
            if (an == 2'b10)      check({nm, " ones"}, 32'(seg), 32'(eo));
            else if (an == 2'b01) check({nm, " tens"}, 32'(seg), 32'(et));
            else                  check({nm, " an"}, 32'(an), 32'(2'b10));
            if (i == 0) begin
                prev = an;
                run = 1;
            end else if (an == prev) begin
                run++;
            end else begin
                if (!first_run) check({nm, " dwell"}, 32'(run), 32'(SCAN_DIV));
                first_run = 1'b0;
                prev = an;
                run = 1;
            end
        end
    endtask

    task automatic meas_busy(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) n++;
        end
    endtask

    initial begin
        int n;
        int v;
        int nchg;

        tbl[0] = '{0,   1'b0, TENS0,      7'b1000000};
        tbl[1] = '{99,  1'b0, 7'b0010000, 7'b0010000};
        tbl[2] = '{100, 1'b1, DASH,       DASH};
        tbl[3] = '{12,  1'b0, 7'b1111001, 7'b0100100};
        tbl[4] = '{7,   1'b0, TENS0,      7'b1111000};
        tbl[5] = '{0,   1'b0, TENS0,      7'b1000000};
        tbl[6] = '{58,  1'b0, 7'b0010010, 7'b0000000};
        tbl[7] = '{127, 1'b1, DASH,       DASH};
        tbl[8] = '{36,  1'b0, 7'b0110000, 7'b0000010};
        tbl[9] = '{64,  1'b0, 7'b0000010, 7'b0011001};

        // Reset held 3 cycles with value 45, then exact busy window
        reset = 1'b1;
        value = 7'd45;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst seg", 32'(seg), 32'(BLANK));
            check("rst an", 32'(an), 32'(2'b11));
            check("rst busy", 32'(busy), 32'd0);
            check("rst ovf", 32'(ovf), 32'd0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("busy window", 32'(busy), 32'd1);
        end
        step();
        check("busy end", 32'(busy), 32'd0);
        check("ovf 45", 32'(ovf), 32'd0);
        step();
        check_disp("disp 45", 7'b0011001, 7'b0010010, 12);

        // Table of isolated changes
        for (int k = 0; k < 10; k++) begin
            value = 7'(tbl[k].v);
            meas_busy(n);
            check($sformatf("busy len %0d", tbl[k].v), 32'(n), 32'd8);
            check($sformatf("ovf %0d", tbl[k].v), 32'(ovf), 32'(tbl[k].exp_ovf));
            check_disp($sformatf("tbl %0d", tbl[k].v), tbl[k].exp_tens, tbl[k].exp_ones, 12);
        end

        // Change during SHIFT: first result shown, second starts right after DONE
        value = 7'd10;
        for (int i = 0; i < 22; i++) step();
        value = 7'd20;
        for (int i = 0; i < 3; i++) step();
        value = 7'd30;
        for (int i = 0; i < 6; i++) step();
        check("mid busy drop", 32'(busy), 32'd0);
        step();
        check("mid busy restart", 32'(busy), 32'd1);
        check_disp("mid 20", exp_seg(20, 1'b1), exp_seg(20, 1'b0), 8);
        for (int i = 0; i < 12; i++) step();
        check_disp("mid 30", exp_seg(30, 1'b1), exp_seg(30, 1'b0), 12);

        // Reset during SHIFT clears a standing overflow and aborts conversion
        value = 7'd100;
        for (int i = 0; i < 20; i++) step();
        check("ovf pre-reset", 32'(ovf), 32'd1);
        value = 7'd88;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        check("abort busy", 32'(busy), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        check("abort an", 32'(an), 32'(2'b11));
        check("abort seg", 32'(seg), 32'(BLANK));
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("ovf 88", 32'(ovf), 32'd0);
        check_disp("disp 88", exp_seg(88, 1'b1), exp_seg(88, 1'b0), 12);

        // Zero right after reset: nothing to convert, shows 00
        reset = 1'b1;
        value = 7'd0;
        step();
        step();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy) n++;
        end
        check("zero no busy", 32'(n), 32'd0);
        check_disp("disp 0", exp_seg(0, 1'b1), exp_seg(0, 1'b0), 12);

        // Random bursts; display must settle on the final stable input
        for (int r = 0; r < 25; r++) begin
            nchg = int'($urandom_range(1, 3));
            v = 0;
            for (int c = 0; c < nchg; c++) begin
                v = int'($urandom_range(0, 127));
                value = 7'(v);
                n = int'($urandom_range(1, 12));
                for (int i = 0; i < n; i++) step();
            end
            for (int i = 0; i < 22; i++) step();
            check($sformatf("rnd ovf %0d", v), 32'(ovf), 32'(v > 99));
            check_disp($sformatf("rnd %0d", v), exp_seg(v, 1'b1), exp_seg(v, 1'b0), 12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
